// File: rtl/ecc_verify_loader_if.sv
// Handshake bundle for ecc_verify_loader: 32-bit word stream in, 2-bit result code out.
// master is the job source / result sink, slave is the loader.
interface ecc_verify_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_code;

    modport master (
        output s_valid,
        output s_data,
        output res_ready,
        input  s_ready,
        input  res_valid,
        input  res_code
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  res_ready,
        output s_ready,
        output res_valid,
        output res_code
    );
endinterface

// File: rtl/ecc_verify_loader.sv
// Front end for ecc_verify: assembles r, s, hash, Px, Py from a 40-word stream, range-checks
// r and s against the group order, runs the core once and reports a 2-bit result code.
module ecc_verify_loader #(
    parameter logic [255:0] CURVE_N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ecc_verify_loader_if.slave    bus,
    output logic [255:0]          r,
    output logic [255:0]          s,
    output logic [255:0]          hash,
    output logic [255:0]          Px,
    output logic [255:0]          Py,
    output logic                  in_valid,
    input  logic                  out_valid,
    input  logic                  fail
);

    typedef enum logic [2:0] {
        StLoad,
        StCheck,
        StIssue,
        StWait,
        StReport
    } state_t;

    localparam logic [1:0] CodePass  = 2'd0;
    localparam logic [1:0] CodeFail  = 2'd1;
    localparam logic [1:0] CodeRange = 2'd2;

    state_t       state_q;
    logic [5:0]   cnt_q;
    logic [255:0] r_q;
    logic [255:0] s_q;
    logic [255:0] hash_q;
    logic [255:0] px_q;
    logic [255:0] py_q;
    logic         s_ready_q;
    logic         in_valid_q;
    logic         res_valid_q;
    logic [1:0]   res_code_q;
    logic         range_bad;
    logic         word_xfer;

    assign word_xfer = bus.s_valid && s_ready_q;

    // Both scalars must lie in [1, n-1].
    assign range_bad = (r_q == '0) || (r_q >= CURVE_N) ||
                       (s_q == '0) || (s_q >= CURVE_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            r_q         <= '0;
            s_q         <= '0;
            hash_q      <= '0;
            px_q        <= '0;
            py_q        <= '0;
            s_ready_q   <= 1'b0;
            in_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_code_q  <= CodePass;
        end else begin
            unique case (state_q)
                StLoad: begin
                    s_ready_q <= 1'b1;
                    if (word_xfer) begin
                        unique case (cnt_q[5:3])
                            3'd0:    r_q    <= {r_q[223:0], bus.s_data};
                            3'd1:    s_q    <= {s_q[223:0], bus.s_data};
                            3'd2:    hash_q <= {hash_q[223:0], bus.s_data};
                            3'd3:    px_q   <= {px_q[223:0], bus.s_data};
                            3'd4:    py_q   <= {py_q[223:0], bus.s_data};
                            default: ;
                        endcase
                        if (cnt_q == 6'd39) begin
                            cnt_q     <= '0;
                            s_ready_q <= 1'b0;
                            state_q   <= StCheck;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                StCheck: begin
                    if (range_bad) begin
                        res_code_q  <= CodeRange;
                        res_valid_q <= 1'b1;
                        state_q     <= StReport;
                    end else begin
                        in_valid_q <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    in_valid_q <= 1'b0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (out_valid) begin
                        res_code_q  <= fail ? CodeFail : CodePass;
                        res_valid_q <= 1'b1;
                        state_q     <= StReport;
                    end
                end
                StReport: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                        state_q     <= StLoad;
                    end
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_code  = res_code_q;
    assign r             = r_q;
    assign s             = s_q;
    assign hash          = hash_q;
    assign Px            = px_q;
    assign Py            = py_q;
    assign in_valid      = in_valid_q;

endmodule

// File: tb/tb_ecc_verify_loader.sv
// Directed bench for ecc_verify_loader: job-level reference model checked every cycle,
// plus literal expectations for result codes, pulse count and one assembled operand.
module tb_ecc_verify_loader;

    localparam logic [255:0] N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
    localparam logic [255:0] NM1 = N - 256'd1;
    localparam logic [255:0] R_GAP =
        256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
    localparam int NumJobs = 9;
    localparam logic [1:0] EXP_CODES [NumJobs] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1,
                                                   2'd0, 2'd0, 2'd0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [255:0] r, s, hash, Px, Py;
    logic         in_valid;
    logic         out_valid;
    logic         fail;

    ecc_verify_loader_if bus();

    ecc_verify_loader #(.CURVE_N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .r        (r),
        .s        (s),
        .hash     (hash),
        .Px       (Px),
        .Py       (Py),
        .in_valid (in_valid),
        .out_valid(out_valid),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  timeouts = 0;
    bit  done = 1'b0;

    // ---------------- reference model (job level) ----------------
    bit           m_s_ready, m_in_valid, m_res_valid;
    logic [1:0]   m_code;
    logic [255:0] m_op [5];
    logic [31:0]  m_words [40];
    int           m_nw;
    bit           m_have_job, m_check, m_wait;
    int           hs_count = 0;
    int           iv_count = 0;
    int           cyc = 0;
    logic [1:0]   codes_log [16];
    logic [255:0] r_gap = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s_ready   = 1'b0;
        m_in_valid  = 1'b0;
        m_res_valid = 1'b0;
        m_code      = 2'd0;
        for (int k = 0; k < 5; k++) m_op[k] = '0;
        m_nw        = 0;
        m_have_job  = 1'b0;
        m_check     = 1'b0;
        m_wait      = 1'b0;
    endtask

    task automatic model_step();
        bit         n_sr, n_iv, n_rv;
        logic [1:0] n_code;
        bit         reject;
        n_sr   = m_s_ready;
        n_iv   = m_in_valid;
        n_rv   = m_res_valid;
        n_code = m_code;
        if (!m_have_job) begin
            n_sr = 1'b1;
            if (m_s_ready && bus.s_valid) begin
                m_words[m_nw] = bus.s_data;
                m_nw++;
                if (m_nw == 40) begin
                    for (int k = 0; k < 5; k++) begin
                        m_op[k] = '0;
                        for (int j = 0; j < 8; j++)
                            m_op[k] = m_op[k] | (256'(m_words[8*k+j]) << (32 * (7 - j)));
                    end
                    m_nw       = 0;
                    m_have_job = 1'b1;
                    m_check    = 1'b1;
                    n_sr       = 1'b0;
                end
            end
        end else if (m_check) begin
            m_check = 1'b0;
            reject = (m_op[0] == 0) || (m_op[0] >= N) || (m_op[1] == 0) || (m_op[1] >= N);
            if (reject) begin
                n_rv   = 1'b1;
                n_code = 2'd2;
            end else begin
                n_iv = 1'b1;
            end
        end else if (m_in_valid) begin
            n_iv   = 1'b0;
            m_wait = 1'b1;
        end else if (m_wait) begin
            if (out_valid) begin
                m_wait = 1'b0;
                n_rv   = 1'b1;
                n_code = fail ? 2'd1 : 2'd0;
            end
        end else if (m_res_valid && bus.res_ready) begin
            n_rv       = 1'b0;
            n_sr       = 1'b1;
            m_have_job = 1'b0;
        end
        m_s_ready   = n_sr;
        m_in_valid  = n_iv;
        m_res_valid = n_rv;
        m_code      = n_code;
    endtask

    // ---------------- compare process ----------------
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) model_reset();
            chk("s_ready", 256'(bus.s_ready), 256'(m_s_ready));
            chk("in_valid", 256'(in_valid), 256'(m_in_valid));
            chk("res_valid", 256'(bus.res_valid), 256'(m_res_valid));
            chk("res_code", 256'(bus.res_code), 256'(m_code));
            if (m_have_job || !rst_n) begin
                chk("r", r, m_op[0]);
                chk("s", s, m_op[1]);
                chk("hash", hash, m_op[2]);
                chk("Px", Px, m_op[3]);
                chk("Py", Py, m_op[4]);
            end
            if (rst_n && in_valid) iv_count++;
            if (rst_n && m_res_valid && bus.res_ready) begin
                if (hs_count < 16) codes_log[hs_count] = bus.res_code;
                if (hs_count == 7) r_gap = r;
                hs_count++;
            end
            if (rst_n) model_step();
            if (done) begin
                chk("handshakes", 256'(hs_count), 256'(NumJobs));
                for (int i = 0; i < NumJobs; i++)
                    chk($sformatf("job%0d_code", i), 256'(codes_log[i]), 256'(EXP_CODES[i]));
                chk("in_valid_pulses", 256'(iv_count), 256'd6);
                chk("r_after_gaps", r_gap, R_GAP);
                chk("wait_timeouts", 256'(timeouts), 256'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            if (cyc > 20000) begin
                $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
                $fatal(1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = bus.s_ready;
            tick();
        end
        if (!acc) timeouts++;
    endtask

    task automatic load_words(input logic [255:0] a, input logic [255:0] b,
                              input logic [255:0] c, input logic [255:0] d,
                              input logic [255:0] e, input int nwords,
                              input bit gaps, input bit stray);
        logic [255:0] ops [5];
        ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d; ops[4] = e;
        for (int i = 0; i < nwords; i++) begin
            if (gaps)
                for (int g = 0; g < 4 && $urandom_range(1) == 1; g++) begin
                    bus.s_valid = 1'b0;
                    tick();
                end
            if (stray && i == 10) begin
                bus.s_valid = 1'b0;
                out_valid   = 1'b1;
                fail        = 1'b1;
                tick();
                out_valid   = 1'b0;
                fail        = 1'b0;
            end
            send_word(ops[i/8][255-32*(i%8) -: 32]);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic finish_job(input bit core_fail, input int bp);
        bit seen_iv, seen_rv;
        seen_iv = 1'b0;
        seen_rv = 1'b0;
        if (bp > 0) begin
            bus.res_ready = 1'b0;
            bus.s_valid   = 1'b1;
            bus.s_data    = 32'hDEAD_BEEF;
        end
        for (int n = 0; n < 10 && !seen_iv && !seen_rv; n++) begin
            @(negedge clk);
            seen_iv = in_valid;
            seen_rv = bus.res_valid;
            tick();
        end
        if (seen_iv) begin
            tick();
            tick();
            out_valid = 1'b1;
            fail      = core_fail;
            tick();
            out_valid = 1'b0;
            fail      = 1'b0;
            for (int n = 0; n < 10 && !seen_rv; n++) begin
                @(negedge clk);
                seen_rv = bus.res_valid;
                tick();
            end
        end
        if (!seen_rv) timeouts++;
        if (bp > 0) begin
            repeat (bp) tick();
            bus.res_ready = 1'b1;
            tick();
            bus.s_valid = 1'b0;
        end
        tick();
    endtask

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.res_ready = 1'b1;
        out_valid     = 1'b0;
        fail          = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // pass path
        load_words(256'd1, 256'd1, 256'd5, 256'h1111_2222, 256'h3333_4444, 40, 1'b0, 1'b0);
        finish_job(1'b0, 0);
        // range rejects
        load_words(256'd0, 256'd1, 256'd5, 256'd6, 256'd7, 40, 1'b0, 1'b0);
        finish_job(1'b0, 0);
        load_words(N, 256'd1, 256'd5, 256'd6, 256'd7, 40, 1'b0, 1'b0);
        finish_job(1'b0, 0);
        load_words(256'd1, N, 256'd5, 256'd6, 256'd7, 40, 1'b0, 1'b0);
        finish_job(1'b0, 0);
        // upper boundary accepted
        load_words(NM1, NM1, {8{32'hA5A5_5A5A}}, 256'd9, 256'd10, 40, 1'b0, 1'b0);
        finish_job(1'b0, 0);
        // signature fail with a stray out_valid during load
        load_words(256'd7, 256'd9, 256'd11, 256'd13, 256'd15, 40, 1'b0, 1'b1);
        finish_job(1'b1, 0);
        // result backpressure with s_valid held high
        load_words(256'd2, 256'd3, 256'd4, 256'd5, 256'd6, 40, 1'b0, 1'b0);
        finish_job(1'b0, 5);
        // random stream gaps
        load_words(R_GAP, 256'h0A_0B_0C, 256'h77, {8{32'h0102_0304}}, 256'h55, 40, 1'b1, 1'b0);
        finish_job(1'b0, 0);
        // reset mid-load, then a fresh job
        load_words(256'h99, 256'h98, 256'h97, 256'h96, 256'h95, 17, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        load_words(256'h42, 256'h43, 256'h44, 256'h45, 256'h46, 40, 1'b0, 1'b0);
        finish_job(1'b0, 0);

        repeat (3) tick();
        done = 1'b1;
    end

endmodule
